// File: rtl/mem_stage_ctrl_if.sv
// Execute/memory latch, cache data port and writeback-side signals of the memory stage.
// slave = the memory-stage controller; master = the surrounding pipeline and cache.
interface mem_stage_ctrl_if;
    logic        ex_dREN;
    logic        ex_dWEN;
    logic [5:0]  ex_opcode;
    logic [31:0] ex_addr;
    logic [31:0] ex_wdat;
    logic        ext_stall;
    logic        dhit;
    logic [31:0] dload;
    logic        link_inv;
    logic        dmemREN;
    logic        dmemWEN;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic        mem_stall;

    modport master (
        output ex_dREN, ex_dWEN, ex_opcode, ex_addr, ex_wdat,
        output ext_stall, dhit, dload, link_inv,
        input  dmemREN, dmemWEN, dmemaddr, dmemstore,
        input  mem_rdata, mem_done, mem_stall
    );

    modport slave (
        input  ex_dREN, ex_dWEN, ex_opcode, ex_addr, ex_wdat,
        input  ext_stall, dhit, dload, link_inv,
        output dmemREN, dmemWEN, dmemaddr, dmemstore,
        output mem_rdata, mem_done, mem_stall
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// Memory-stage request/stall controller with LL/SC link register; requests issue combinationally,
// mem_done pulses the edge after dhit, and mem_stall holds upstream while dhit is low.
module mem_stage_ctrl #(
    parameter logic [5:0] OP_LL = 6'b110000,
    parameter logic [5:0] OP_SC = 6'b111000
) (
    input logic             CLK,
    input logic             RST,
    mem_stage_ctrl_if.slave mif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] HELD = 2'd2;

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic        link_valid;
    logic [31:0] link_addr;
    logic [31:0] data_q;
    logic        done_q;

    logic [31:0] word_addr;
    logic        req;
    logic        is_rd;
    logic        is_wr;
    logic        is_ll;
    logic        is_sc;
    logic        sc_fail;
    logic        active;
    logic        complete;
    logic [31:0] cap_dat;

    assign word_addr = mif.ex_addr & 32'hFFFF_FFFC;
    assign req       = mif.ex_dREN | mif.ex_dWEN;
    // Read wins when both enables are set, so a write is never issued alongside it.
    assign is_rd     = mif.ex_dREN;
    assign is_wr     = mif.ex_dWEN & ~mif.ex_dREN;
    assign is_ll     = is_rd & (mif.ex_opcode == OP_LL);
    assign is_sc     = is_wr & (mif.ex_opcode == OP_SC);

    // The link check is only made on entry; once in WAIT the SC write is committed.
    assign sc_fail   = (state == IDLE) & is_sc &
                       ~(link_valid & (link_addr == word_addr));

    assign active    = ((state == IDLE) & req & ~sc_fail) | (state == WAIT);
    assign complete  = ((state == IDLE) & req & (mif.dhit | sc_fail)) |
                       ((state == WAIT) & mif.dhit);
    assign cap_dat   = is_sc ? {31'd0, ~sc_fail} : mif.dload;

    assign mif.dmemREN   = active & is_rd;
    assign mif.dmemWEN   = active & is_wr;
    assign mif.dmemaddr  = word_addr;
    assign mif.dmemstore = mif.ex_wdat;
    assign mif.mem_stall = active & ~mif.dhit;
    assign mif.mem_rdata = data_q;
    assign mif.mem_done  = done_q;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (complete)
                    state_nxt = mif.ext_stall ? HELD : IDLE;
                else if (req)
                    state_nxt = WAIT;
            end
            WAIT: begin
                if (complete)
                    state_nxt = mif.ext_stall ? HELD : IDLE;
            end
            HELD: begin
                if (!mif.ext_stall)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            data_q <= 32'd0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= complete;
            if (complete)
                data_q <= cap_dat;
        end
    end

    // An LL completing in the same cycle as an invalidate keeps its new link.
    always_ff @(posedge CLK) begin
        if (RST) begin
            link_valid <= 1'b0;
            link_addr  <= 32'd0;
        end else if (complete & is_ll) begin
            link_valid <= 1'b1;
            link_addr  <= word_addr;
        end else if (mif.link_inv) begin
            link_valid <= 1'b0;
        end else if (complete & is_wr & (is_sc | (word_addr == link_addr))) begin
            link_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Randomized transaction-level bench for mem_stage_ctrl against a per-operation link/data model.
module tb_mem_stage_ctrl;

    localparam logic [5:0] OP_LL = 6'b110000;
    localparam logic [5:0] OP_SC = 6'b111000;
    localparam logic [5:0] OP_LW = 6'b100011;
    localparam logic [5:0] OP_SW = 6'b101011;

    localparam int K_LW   = 0;
    localparam int K_SW   = 1;
    localparam int K_LL   = 2;
    localparam int K_SC   = 3;
    localparam int K_BOTH = 4;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    mem_stage_ctrl_if mif();

    mem_stage_ctrl #(.OP_LL(OP_LL), .OP_SC(OP_SC)) dut (
        .CLK (CLK),
        .RST (RST),
        .mif (mif)
    );

    always #5 CLK = ~CLK;

    int          n_chk   = 0;
    int          n_fail  = 0;
    int          inv_pct = 0;
    logic        inv_op  = 1'b0;
    logic        m_lv    = 1'b0;
    logic [31:0] m_la    = 32'd0;
    logic [31:0] m_rd    = 32'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One instruction through the stage: request cycles, then either a bubble or a held period.
    task automatic do_op(input int kind, input logic [31:0] addr, input logic [31:0] wdat,
                         input logic [31:0] dl, input int misses, input int hold);
        logic [5:0]  op;
        logic        rd, wr, is_sc, issue, inv, chk_rd;
        logic [31:0] wa;
        int          ncyc, npost;
        rd     = (kind == K_LW) || (kind == K_LL) || (kind == K_BOTH);
        wr     = (kind == K_SW) || (kind == K_SC) || (kind == K_BOTH);
        op     = (kind == K_LL) ? OP_LL : (kind == K_SC || kind == K_BOTH) ? OP_SC :
                 (kind == K_SW) ? OP_SW : OP_LW;
        wa     = {addr[31:2], 2'b00};
        is_sc  = wr && !rd && (op == OP_SC);
        issue  = !(is_sc && !(m_lv && m_la == wa));
        ncyc   = issue ? misses + 1 : 1;
        chk_rd = rd || is_sc;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge CLK);
            mif.ex_dREN   = rd;
            mif.ex_dWEN   = wr;
            mif.ex_opcode = op;
            mif.ex_addr   = addr;
            mif.ex_wdat   = wdat;
            mif.dhit      = issue ? (i == misses) : 1'($urandom_range(0, 1));
            mif.dload     = (issue && i != misses) ? $urandom : dl;
            mif.ext_stall = (i == ncyc - 1) && (hold > 0);
            inv           = inv_op || ($urandom_range(0, 99) < inv_pct);
            mif.link_inv  = inv;
            #1;
            chk("dmemREN",   mif.dmemREN,   issue && rd);
            chk("dmemWEN",   mif.dmemWEN,   issue && wr && !rd);
            chk("mem_stall", mif.mem_stall, issue && (i < misses));
            chk("mem_done",  mif.mem_done,  0);
            chk("dmemaddr",  mif.dmemaddr,  wa);
            chk("dmemstore", mif.dmemstore, wdat);
            if (i == ncyc - 1) begin
                m_rd = is_sc ? {31'd0, issue} : dl;
                if (rd && op == OP_LL) begin
                    m_lv = 1'b1;
                    m_la = wa;
                end else if (inv) begin
                    m_lv = 1'b0;
                end else if (wr && !rd && (is_sc ? issue : (wa == m_la))) begin
                    m_lv = 1'b0;
                end
            end else if (inv) begin
                m_lv = 1'b0;
            end
        end
        npost = (hold > 0) ? hold : 1;
        for (int j = 0; j < npost; j++) begin
            @(negedge CLK);
            if (hold == 0) begin
                mif.ex_dREN   = 1'b0;
                mif.ex_dWEN   = 1'b0;
                mif.ext_stall = 1'b0;
            end else begin
                mif.ext_stall = (j < hold - 1);
            end
            mif.dhit     = 1'($urandom_range(0, 1));
            mif.dload    = $urandom;
            inv          = ($urandom_range(0, 99) < inv_pct);
            mif.link_inv = inv;
            #1;
            chk("post_dmemREN",   mif.dmemREN,   0);
            chk("post_dmemWEN",   mif.dmemWEN,   0);
            chk("post_mem_stall", mif.mem_stall, 0);
            chk("post_mem_done",  mif.mem_done,  j == 0);
            if (chk_rd)
                chk("mem_rdata", mif.mem_rdata, m_rd);
            if (inv)
                m_lv = 1'b0;
        end
    endtask

    task automatic idle_inv();
        @(negedge CLK);
        mif.ex_dREN   = 1'b0;
        mif.ex_dWEN   = 1'b0;
        mif.ext_stall = 1'b0;
        mif.link_inv  = 1'b1;
        #1;
        chk("inv_dmemREN", mif.dmemREN, 0);
        chk("inv_mem_done", mif.mem_done, 0);
        m_lv = 1'b0;
    endtask

    initial begin
        int          kind;
        int          sel;
        logic [31:0] a;

        mif.ex_dREN   = 1'b0;
        mif.ex_dWEN   = 1'b0;
        mif.ex_opcode = 6'd0;
        mif.ex_addr   = 32'h0000_1237;
        mif.ex_wdat   = 32'hCAFE_F00D;
        mif.ext_stall = 1'b0;
        mif.dhit      = 1'b0;
        mif.dload     = 32'd0;
        mif.link_inv  = 1'b0;

        repeat (2) @(negedge CLK);
        #1;
        chk("rst_dmemREN",   mif.dmemREN,   0);
        chk("rst_dmemWEN",   mif.dmemWEN,   0);
        chk("rst_mem_stall", mif.mem_stall, 0);
        chk("rst_mem_done",  mif.mem_done,  0);
        chk("rst_mem_rdata", mif.mem_rdata, 0);
        chk("rst_dmemaddr",  mif.dmemaddr,  32'h0000_1234);
        chk("rst_dmemstore", mif.dmemstore, 32'hCAFE_F00D);
        @(negedge CLK);
        RST = 1'b0;

        do_op(K_LW, 32'h104, 32'h0, 32'hDEADBEEF, 0, 0);
        do_op(K_SW, 32'h200, 32'h5A5A, 32'h0, 3, 0);
        do_op(K_LW, 32'h108, 32'h0, 32'h1111_2222, 1, 4);
        do_op(K_LW, 32'h10C, 32'h0, 32'h0000_3333, 0, 0);
        do_op(K_BOTH, 32'h110, 32'h9, 32'h4444_5555, 2, 0);

        do_op(K_LL, 32'h300, 32'h0, 32'h77, 0, 0);
        do_op(K_SC, 32'h300, 32'hAB, 32'h0, 1, 0);
        do_op(K_SC, 32'h300, 32'hAC, 32'h0, 2, 0);

        do_op(K_LL, 32'h300, 32'h0, 32'h78, 0, 0);
        do_op(K_SW, 32'h302, 32'h1, 32'h0, 1, 0);
        do_op(K_SC, 32'h300, 32'hAD, 32'h0, 0, 0);

        do_op(K_LL, 32'h300, 32'h0, 32'h79, 1, 0);
        idle_inv();
        do_op(K_SC, 32'h300, 32'hAE, 32'h0, 0, 0);

        // Invalidate arriving with an LL completion, then during an SC already waiting.
        inv_op = 1'b1;
        do_op(K_LL, 32'h304, 32'h0, 32'h7A, 0, 0);
        inv_op = 1'b0;
        do_op(K_SC, 32'h304, 32'hAF, 32'h0, 0, 0);
        do_op(K_LL, 32'h304, 32'h0, 32'h7B, 0, 0);
        inv_op = 1'b1;
        do_op(K_SC, 32'h304, 32'hB0, 32'h0, 2, 0);
        inv_op = 1'b0;

        // Reset while a load is waiting on the cache.
        do_op(K_LL, 32'h300, 32'h0, 32'h55, 0, 0);
        @(negedge CLK);
        mif.ex_dREN   = 1'b1;
        mif.ex_dWEN   = 1'b0;
        mif.ex_opcode = OP_LW;
        mif.ex_addr   = 32'h400;
        mif.dhit      = 1'b0;
        mif.link_inv  = 1'b0;
        mif.ext_stall = 1'b0;
        #1;
        chk("rstw_mem_stall", mif.mem_stall, 1);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        chk("rstw_dmemREN_hold", mif.dmemREN, 1);
        @(negedge CLK);
        RST         = 1'b0;
        mif.ex_dREN = 1'b0;
        #1;
        chk("rstw_dmemREN",   mif.dmemREN,   0);
        chk("rstw_mem_stall", mif.mem_stall, 0);
        chk("rstw_mem_done",  mif.mem_done,  0);
        chk("rstw_mem_rdata", mif.mem_rdata, 0);
        m_lv = 1'b0;
        m_rd = 32'd0;
        do_op(K_SC, 32'h300, 32'hB1, 32'h0, 0, 0);

        inv_pct = 8;
        for (int t = 0; t < 250; t++) begin
            sel  = $urandom_range(0, 9);
            kind = (sel < 3) ? K_LW : (sel < 5) ? K_SW : (sel < 7) ? K_LL :
                   (sel < 9) ? K_SC : K_BOTH;
            case ($urandom_range(0, 3))
                0:       a = 32'h300;
                1:       a = 32'h304;
                2:       a = 32'h100;
                default: a = $urandom & 32'h0000_0FFC;
            endcase
            a = a | 32'($urandom_range(0, 3));
            do_op(kind, a, $urandom, $urandom, $urandom_range(0, 3),
                  ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
